// File: rtl/branch_hazard_controller.sv
// branch_hazard_controller
// Control-hazard unit for the pipelined MIPS core. It watches the decode-stage
// opcode for conditional branches (BEQ/BNE) and jumps (J/JAL), and tracks one
// outstanding branch with a down-counter until its resolution stage. Depending
// on PREDICT it either freezes fetch/decode until the branch resolves, or lets
// fetch run predict-not-taken and squashes the wrong path on a taken branch.
// All outputs are combinational from the tracking state and the current decode
// inputs; only the state and the counter are registered.

module branch_hazard_controller #(
    parameter int OP_W           = 6,
    parameter int RESOLVE_CYCLES = 2,
    parameter int PREDICT        = 0,
    parameter int BEQ_OP         = 4,
    parameter int BNE_OP         = 5,
    parameter int J_OP           = 2,
    parameter int JAL_OP         = 3
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            Jump,
    input  logic            Branch,
    input  logic [OP_W-1:0] Op,
    input  logic            Taken,
    output logic            outJump,
    output logic            outBranch,
    output logic            stall,
    output logic            flush
);

    // Counter reload value: the resolution cycle is the one where the counter
    // reads 1, which lands exactly RESOLVE_CYCLES cycles after the accept.
    localparam logic [2:0] RES_CNT   = 3'(RESOLVE_CYCLES);
    localparam bit         PRED_MODE = (PREDICT != 0);

    // Opcode tables for the two instruction classes this unit reacts to.
    localparam logic [OP_W-1:0] BR_CODES  [2] = '{OP_W'(BEQ_OP), OP_W'(BNE_OP)};
    localparam logic [OP_W-1:0] JMP_CODES [2] = '{OP_W'(J_OP),   OP_W'(JAL_OP)};

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t     state_reg;
    logic [2:0] cnt_reg;

    logic [1:0] br_hit;
    logic [1:0] jmp_hit;
    logic       br_op;
    logic       jmp_det;
    logic       tracking;
    logic       resolve;

    // The decoder's Branch flag is advisory only: detection is done on the
    // opcode so that a mis-decoded control bit cannot open a hazard window.
    logic       unused_branch;
    assign unused_branch = Branch;

    // Per-opcode comparators for branch and jump classes.
    for (genvar gi = 0; gi < 2; gi++) begin : g_op_match
        assign br_hit[gi]  = (Op == BR_CODES[gi]);
        assign jmp_hit[gi] = (Op == JMP_CODES[gi]);
    end

    assign br_op    = |br_hit;
    assign jmp_det  = Jump & (|jmp_hit);
    assign tracking = (state_reg == TRACK);
    assign resolve  = tracking && (cnt_reg == 3'd1);

    // Branch tracking FSM: accept a branch from IDLE, count down in TRACK, and
    // leave at the resolution cycle unless predict mode re-accepts a branch
    // that was waiting in decode behind a not-taken outcome.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (br_op) begin
                        state_reg <= TRACK;
                        cnt_reg   <= RES_CNT;
                    end
                end
                TRACK: begin
                    if (resolve) begin
                        // In stall mode decode was frozen, so Op is stale and
                        // must not start a new branch. A taken redirect makes
                        // whatever sits in decode wrong-path.
                        if (PRED_MODE && !Taken && br_op) begin
                            cnt_reg <= RES_CNT;
                        end else begin
                            state_reg <= IDLE;
                            cnt_reg   <= 3'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 3'd0;
                end
            endcase
        end
    end

    // Output decode: PC-select gating, stall and flush from state and decode.
    always_comb begin
        outJump   = Jump;
        outBranch = 1'b0;
        stall     = 1'b0;
        flush     = jmp_det;

        if (tracking) begin
            if (!PRED_MODE) begin
                // Fetch and decode are frozen for the whole tracking window;
                // nothing younger was fetched, so there is nothing to squash.
                stall     = 1'b1;
                outJump   = 1'b0;
                flush     = 1'b0;
                outBranch = resolve & Taken;
            end else if (resolve && Taken) begin
                // Redirect wins over any jump in decode; both it and the
                // already-fetched fall-through path are discarded.
                outBranch = 1'b1;
                flush     = 1'b1;
                outJump   = 1'b0;
            end else if (!resolve && br_op) begin
                // Only one branch is tracked: hold a second one in decode
                // until the first resolves.
                stall = 1'b1;
            end
        end
    end

endmodule
